// File: rtl/lp805x_mon_pkg.sv
// Shared types and codes for the lp805x port-0 exit monitor.
// Imported by the monitor top and its counter.
package lp805x_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_QUAL   = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } mon_state_e;

  localparam logic [7:0] DEF_IDLE_CODE = 8'hFF;
  localparam logic [7:0] DEF_PASS_CODE = 8'h7F;
  localparam logic [7:0] TMO_CODE      = 8'h00;

endpackage

// File: rtl/lp805x_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping.
module lp805x_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lp805x_exit_mon.sv
// Watches p0 for the self-test exit code, qualifies it and
// reports pass/fail, code and cycle count via done/ack.
module lp805x_exit_mon
  import lp805x_mon_pkg::*;
#(
  parameter int         CNT_W      = 32,
  parameter logic [7:0] IDLE_CODE  = DEF_IDLE_CODE,
  parameter logic [7:0] PASS_CODE  = DEF_PASS_CODE,
  parameter int         STABLE_CYC = 2,
  parameter int         TIMEOUT    = 0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [7:0]       p0_i,
  input  logic             ack_i,
  input  logic             rearm_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [7:0]       code_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [3:0] STAB_N = 4'(STABLE_CYC);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  mon_state_e       state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cand_cyc_q, cand_cyc_d;
  logic [3:0]       stab_q, stab_d;
  logic [7:0]       code_q, code_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             pass_q, pass_d;
  logic             tmo_q, tmo_d;

  logic             clr;
  logic             cnt_en;
  logic             to_hit;
  logic [CNT_W-1:0] cnt;

  assign clr    = !wb_rst_i || rearm_i;
  assign cnt_en = (state_q == ST_RUN) ||
                  (state_q == ST_QUAL);
  assign to_hit = TO_EN && (cnt == TO_LAST);

  lp805x_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (wb_clk_i),
    .clr   (clr),
    .en    (cnt_en),
    .cnt_o (cnt)
  );

  // next state and result capture; acceptance beats timeout
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cand_cyc_d = cand_cyc_q;
    stab_d     = stab_q;
    code_d     = code_q;
    cycles_d   = cycles_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    if (clr) begin
      state_d    = ST_RUN;
      cand_d     = '0;
      cand_cyc_d = '0;
      stab_d     = '0;
      code_d     = '0;
      cycles_d   = '0;
      pass_d     = 1'b0;
      tmo_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (p0_i != IDLE_CODE) begin
            cand_d     = p0_i;
            cand_cyc_d = cnt;
            stab_d     = 4'd1;
            if (STAB_N == 4'd1) begin
              state_d  = ST_REPORT;
              code_d   = p0_i;
              cycles_d = cnt;
              pass_d   = (p0_i == PASS_CODE);
              tmo_d    = 1'b0;
            end else begin
              state_d = ST_QUAL;
            end
          end else if (to_hit) begin
            state_d  = ST_REPORT;
            code_d   = TMO_CODE;
            cycles_d = TO_VAL;
            pass_d   = 1'b0;
            tmo_d    = 1'b1;
          end
        end
        ST_QUAL: begin
          if (p0_i == cand_q &&
              stab_q + 4'd1 == STAB_N) begin
            stab_d   = stab_q + 4'd1;
            state_d  = ST_REPORT;
            code_d   = cand_q;
            cycles_d = cand_cyc_q;
            pass_d   = (cand_q == PASS_CODE);
            tmo_d    = 1'b0;
          end else if (to_hit) begin
            state_d  = ST_REPORT;
            code_d   = TMO_CODE;
            cycles_d = TO_VAL;
            pass_d   = 1'b0;
            tmo_d    = 1'b1;
          end else if (p0_i == cand_q) begin
            stab_d = stab_q + 4'd1;
          end else if (p0_i == IDLE_CODE) begin
            state_d = ST_RUN;
            stab_d  = '0;
          end else begin
            cand_d     = p0_i;
            cand_cyc_d = cnt;
            stab_d     = 4'd1;
          end
        end
        ST_REPORT: begin
          if (ack_i) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  // state and result registers
  always_ff @(posedge wb_clk_i) begin
    state_q    <= state_d;
    cand_q     <= cand_d;
    cand_cyc_q <= cand_cyc_d;
    stab_q     <= stab_d;
    code_q     <= code_d;
    cycles_q   <= cycles_d;
    pass_q     <= pass_d;
    tmo_q      <= tmo_d;
  end

  assign busy_o    = cnt_en;
  assign done_o    = (state_q == ST_REPORT);
  assign pass_o    = pass_q;
  assign timeout_o = tmo_q;
  assign code_o    = code_q;
  assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_lp805x_exit_mon.sv
// Scoreboard bench for lp805x_exit_mon: stimulus queues expected
// reports, per-DUT monitors pop and compare on done_o rising.
module tb_lp805x_exit_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m, rst_s, ack, rearm;
  logic [7:0] p0;

  logic        busy_m, done_m, pass_m, tmo_m;
  logic [7:0]  code_m;
  logic [31:0] cyc_m;

  logic        busy_s, done_s, pass_s, tmo_s;
  logic [7:0]  code_s;
  logic [3:0]  cyc_s;

  int checks = 0;
  int failures = 0;
  int tb_cyc = 0;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  typedef struct {
    logic [7:0]  code;
    logic        pass;
    logic        tmo;
    logic [31:0] cyc;
    int          at;
  } exp_t;

  exp_t sb_m[$];
  exp_t sb_s[$];

  lp805x_exit_mon #(
    .CNT_W      (32),
    .STABLE_CYC (2),
    .TIMEOUT    (1000)
  ) u_main (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_m),
    .p0_i      (p0),
    .ack_i     (ack),
    .rearm_i   (rearm),
    .busy_o    (busy_m),
    .done_o    (done_m),
    .pass_o    (pass_m),
    .timeout_o (tmo_m),
    .code_o    (code_m),
    .cycles_o  (cyc_m)
  );

  lp805x_exit_mon #(
    .CNT_W      (4),
    .STABLE_CYC (2),
    .TIMEOUT    (0)
  ) u_sat (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_s),
    .p0_i      (p0),
    .ack_i     (ack),
    .rearm_i   (rearm),
    .busy_o    (busy_s),
    .done_o    (done_s),
    .pass_o    (pass_s),
    .timeout_o (tmo_s),
    .code_o    (code_s),
    .cycles_o  (cyc_s)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  logic dprev_m = 1'b0;
  logic dprev_s = 1'b0;

  always @(negedge clk) begin
    if (done_m === 1'b1 && dprev_m !== 1'b1) begin
      if (sb_m.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_spurious actual=%0h required=none",
                 code_m);
      end else begin
        exp_t e;
        e = sb_m.pop_front();
        chk("main_code", 32'(code_m), 32'(e.code));
        chk("main_pass", 32'(pass_m), 32'(e.pass));
        chk("main_tmo", 32'(tmo_m), 32'(e.tmo));
        chk("main_cycles", cyc_m, e.cyc);
        chk("main_busy", 32'(busy_m), 32'd0);
        chk("main_done_at", tb_cyc, e.at);
      end
    end
    dprev_m <= done_m;
  end

  always @(negedge clk) begin
    if (done_s === 1'b1 && dprev_s !== 1'b1) begin
      if (sb_s.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sat_spurious actual=%0h required=none",
                 code_s);
      end else begin
        exp_t e;
        e = sb_s.pop_front();
        chk("sat_code", 32'(code_s), 32'(e.code));
        chk("sat_pass", 32'(pass_s), 32'(e.pass));
        chk("sat_tmo", 32'(tmo_s), 32'(e.tmo));
        chk("sat_cycles", 32'(cyc_s), e.cyc);
        chk("sat_done_at", tb_cyc, e.at);
      end
    end
    dprev_s <= done_s;
  end

  task automatic wait_sb(input bit sat, input int budget,
                         input string name);
    int n = 0;
    while ((sat ? sb_s.size() : sb_m.size()) != 0 &&
           n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if ((sat ? sb_s.size() : sb_m.size()) != 0) begin
      failures++;
      $display("FAIL %s_wait actual=no_report required=%0d",
               name, budget);
      if (sat) sb_s.delete();
      else sb_m.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_busy"}, 32'(busy_m), 32'd1);
    chk({name, "_done"}, 32'(done_m), 32'd0);
    chk({name, "_pass"}, 32'(pass_m), 32'd0);
    chk({name, "_tmo"}, 32'(tmo_m), 32'd0);
    chk({name, "_code"}, 32'(code_m), 32'd0);
    chk({name, "_cycles"}, cyc_m, 32'd0);
  endtask

  task automatic restart_rearm(output int start);
    p0 = 8'hFF;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    start = tb_cyc;
  endtask

  task automatic push_m(input logic [7:0] c, input logic ps,
                        input logic t, input logic [31:0] cy,
                        input int at);
    exp_t e;
    e.code = c;
    e.pass = ps;
    e.tmo = t;
    e.cyc = cy;
    e.at = at;
    sb_m.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=hung required=finish");
    $fatal(1);
  end

  initial begin
    int start;
    exp_t es;
    rst_m = 1'b0;
    rst_s = 1'b0;
    ack = 1'b0;
    rearm = 1'b0;
    p0 = 8'hFF;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");

    // pass path
    rst_m = 1'b1;
    start = tb_cyc;
    repeat (100) @(negedge clk);
    p0 = 8'h7F;
    push_m(8'h7F, 1'b1, 1'b0, 32'd100, start + 102);
    wait_sb(1'b0, 20, "pass");

    // rearm out of REPORT
    restart_rearm(start);
    chk_reset_outs("rearm");

    // fail path with ack
    repeat (50) @(negedge clk);
    p0 = 8'h03;
    push_m(8'h03, 1'b0, 1'b0, 32'd50, start + 52);
    wait_sb(1'b0, 20, "fail");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_done", 32'(done_m), 32'd0);
    chk("ack_busy", 32'(busy_m), 32'd0);
    chk("ack_code", 32'(code_m), 32'h03);
    chk("ack_cycles", cyc_m, 32'd50);
    chk("ack_pass", 32'(pass_m), 32'd0);
    repeat (3) @(negedge clk);
    chk("halt_hold", 32'(done_m), 32'd0);

    // one-cycle glitch must be rejected
    restart_rearm(start);
    repeat (20) @(negedge clk);
    p0 = 8'h05;
    @(negedge clk);
    p0 = 8'hFF;
    repeat (179) @(negedge clk);
    p0 = 8'h7F;
    push_m(8'h7F, 1'b1, 1'b0, 32'd200, start + 202);
    wait_sb(1'b0, 20, "glitch");

    // reset while qualifying restarts everything
    restart_rearm(start);
    repeat (10) @(negedge clk);
    p0 = 8'h03;
    @(negedge clk);
    rst_m = 1'b0;
    @(negedge clk);
    chk_reset_outs("qrst");
    @(negedge clk);
    rst_m = 1'b1;
    start = tb_cyc;
    push_m(8'h03, 1'b0, 1'b0, 32'd0, start + 2);
    wait_sb(1'b0, 20, "qrst_rerun");

    // timeout
    rst_m = 1'b0;
    p0 = 8'hFF;
    repeat (2) @(negedge clk);
    rst_m = 1'b1;
    start = tb_cyc;
    push_m(8'h00, 1'b0, 1'b1, 32'd1000, start + 1000);
    wait_sb(1'b0, 1100, "timeout");

    // saturation on the 4-bit instance
    rst_m = 1'b0;
    p0 = 8'hFF;
    @(negedge clk);
    rst_s = 1'b1;
    start = tb_cyc;
    repeat (30) @(negedge clk);
    p0 = 8'h7F;
    es.code = 8'h7F;
    es.pass = 1'b1;
    es.tmo = 1'b0;
    es.cyc = 32'hF;
    es.at = start + 32;
    sb_s.push_back(es);
    wait_sb(1'b1, 20, "sat");

    repeat (5) @(negedge clk);
    chk("main_sb_empty", 32'(sb_m.size()), 32'd0);
    chk("sat_sb_empty", 32'(sb_s.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lp805x_exit_mon.md
Name: lp805x_exit_mon

Overview:
- Synthesizable on-chip monitor for the port-0 exit-code protocol used by the lp805x self-test firmware.
- Firmware holds P0 at the idle code while running, then writes a completion code: PASS_CODE for success, any other value for a failure code.
- This block sits on the core's p0_o bus. It counts clock cycles from reset release, qualifies and latches the final code, and presents pass/fail, code and cycle count to a host through a done/ack handshake.
- It replaces simulation-only result checking on FPGA and silicon builds.

Parameters:
- CNT_W, 32, width of cycle counter and cycles_o.
- IDLE_CODE, 8'hFF, P0 value meaning "test still running".
- PASS_CODE, 8'h7F, P0 value meaning "test passed".
- STABLE_CYC, 2, consecutive cycles a non-idle code must hold before it is accepted (range 1..15).
- TIMEOUT, 0, cycle limit before forced failure; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- p0_i  in  8  core port-0 output (p0_o of lp805x_top).
- ack_i  in  1  host acknowledge of a reported result.
- rearm_i  in  1  restart monitoring without a core reset.
- busy_o  out  1  monitoring in progress.
- done_o  out  1  result valid; held until acknowledged.
- pass_o  out  1  result was PASS_CODE.
- timeout_o  out  1  result was forced by timeout.
- code_o  out  8  latched exit code.
- cycles_o  out  CNT_W  cycles from reset release to first appearance of the accepted code.

Behaviour:
- Reset: on any rising clock edge with wb_rst_i=0:
  - state=RUN, counter=0, stability count=0.
  - busy_o=1, done_o=0, pass_o=0, timeout_o=0, code_o=8'h00, cycles_o=0.
- Reset mid-operation (any state) aborts immediately, with the same values as above.
- Cycle counter:
  - Increments by 1 every cycle in RUN and QUAL.
  - Saturates at all-ones and never wraps.
  - Frozen in REPORT and HALT.
- States:
  - RUN:
    - If p0_i != IDLE_CODE: capture cand=p0_i and cand_cyc=counter, set stab=1, go to QUAL. If STABLE_CYC==1, go directly to REPORT with cand.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to REPORT with code_o=8'h00, timeout_o=1, pass_o=0, cycles_o=TIMEOUT.
  - QUAL:
    - If p0_i==cand: stab++. When stab reaches STABLE_CYC, go to REPORT with code_o=cand and cycles_o=cand_cyc.
    - If p0_i==IDLE_CODE: glitch; return to RUN (counter keeps running).
    - If p0_i is a different non-idle value: recapture cand and cand_cyc=counter, set stab=1, stay in QUAL.
    - Timeout is also checked in QUAL. When timeout and acceptance coincide in the same cycle, acceptance wins.
  - REPORT:
    - done_o=1, busy_o=0, pass_o=(code_o==PASS_CODE).
    - Outputs are stable and p0_i is ignored.
    - ack_i=1 moves to HALT on the next edge.
  - HALT:
    - done_o=0; pass_o, code_o, cycles_o and timeout_o are retained.
    - Only reset or rearm leaves HALT.
- Result latching: done_o rises exactly 1 cycle after the edge where the acceptance/timeout condition is sampled.
- ack_i is ignored outside REPORT. If ack_i is held high at REPORT entry, the block spends 1 cycle in REPORT and then goes to HALT.
- rearm_i=1, in any state:
  - Next state is RUN with counter=0 and all outputs at reset values.
  - rearm has priority over ack and acceptance.
- Widths:
  - stab counter is 4 bits.
  - TIMEOUT is compared as a CNT_W-bit value.

Decomposition:
- Shared package lp805x_mon_pkg holds:
  - state encoding (RUN, QUAL, REPORT, HALT);
  - default IDLE/PASS codes;
  - timeout result code 8'h00.
- One natural sub-module: lp805x_sat_cnt, a CNT_W-bit saturating counter with enable and synchronous clear. The top block instantiates it once.

Test Plan:
- Pass path: reset low 2 cycles, p0_i=FF for 100 cycles, then 7F held -> done_o=1, pass_o=1, code_o=7F, cycles_o=100, busy_o=0.
- Fail path: p0_i=FF for 50 cycles, then 03 held -> done_o=1, pass_o=0, code_o=03, cycles_o=50. ack_i pulse -> done_o=0 next cycle, code retained.
- Glitch rejection (STABLE_CYC=2): p0_i=FF, one-cycle 05, back to FF, later 7F held at cycle 200 -> code_o=7F, cycles_o=200, no report of 05.
- Timeout (TIMEOUT=1000): p0_i fixed FF -> done_o=1 at cycle 1001, timeout_o=1, code_o=00, cycles_o=1000.
- Reset/rearm: assert wb_rst_i=0 while in QUAL -> all outputs at reset values next edge. After REPORT, rearm_i=1 -> busy_o=1, done_o=0, counter restarts from 0.
- Saturation (CNT_W=4, TIMEOUT=0): p0_i=FF for 30 cycles, then 7F held -> cycles_o=4'hF, pass_o=1.
